// File: rtl/package_settings.sv
// package_settings: shared datapath widths
package package_settings;
  localparam int SIZE_DATA = 16;
endpackage

// File: rtl/sqrt_scheduler.sv
// sqrt_scheduler: round-robin sharing of one pipelined sqrt unit among NUM_REQ requesters
module sqrt_scheduler
  import package_settings::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int SQRT_LATENCY = 18
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*SIZE_DATA-1:0]  req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [SIZE_DATA-1:0]          sqrt_in_data,
  input  logic signed [SIZE_DATA-1:0]   sqrt_out_data,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic signed [SIZE_DATA-1:0]   rsp_data,
  output logic                          busy
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0]         last_grant;
  logic [IW-1:0]         grant_idx;
  logic                  grant;
  logic [SQRT_LATENCY:0] tag_v;
  logic [IW-1:0]         tag_i [SQRT_LATENCY+1];
  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (enable && reset && !grant && req_valid[(int'(last_grant) + 1 + k) % NUM_REQ]) begin
        grant     = 1'b1;
        grant_idx = IW'((int'(last_grant) + 1 + k) % NUM_REQ);
      end
    end
    req_ready[grant_idx] = grant;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant   <= IW'(NUM_REQ - 1);
      sqrt_in_data <= '0;
      tag_v        <= '0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
    end else begin
      if (grant) begin
        last_grant   <= grant_idx;
        sqrt_in_data <= req_data[grant_idx*SIZE_DATA +: SIZE_DATA];
      end
      tag_v     <= {tag_v[SQRT_LATENCY-1:0], grant};
      rsp_valid <= tag_v[SQRT_LATENCY] ? NUM_REQ'(1) << tag_i[SQRT_LATENCY] : '0;
      if (tag_v[SQRT_LATENCY]) rsp_data <= sqrt_out_data;
    end
  end
  // Indices need no reset: they are only consumed alongside a valid bit.
  always_ff @(posedge clk) begin
    tag_i[0] <= grant_idx;
    for (int k = 1; k <= SQRT_LATENCY; k++) tag_i[k] <= tag_i[k-1];
  end
  assign busy = |tag_v | |rsp_valid;
endmodule

// File: tb/tb_sqrt_scheduler.sv
// tb_sqrt_scheduler: directed checks of arbitration, latency, fairness, enable and reset
module tb_sqrt_scheduler;
  localparam int N = 4;
  localparam int L = 18;
  localparam int W = 16;
  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b1;
  logic [N-1:0]      req_valid = '1;
  logic [N*W-1:0]    req_data = '0;
  logic [N-1:0]      req_ready;
  logic [W-1:0]      sqrt_in_data;
  logic signed [W-1:0] sqrt_out_data;
  logic [N-1:0]      rsp_valid;
  logic signed [W-1:0] rsp_data;
  logic              busy;
  logic [W-1:0]      pipe [L];
  int                checks = 0;
  int                errors = 0;
  logic [N-1:0]      seen;

  sqrt_scheduler #(.NUM_REQ(N), .SQRT_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .enable(enable), .req_valid(req_valid),
    .req_data(req_data), .req_ready(req_ready), .sqrt_in_data(sqrt_in_data),
    .sqrt_out_data(sqrt_out_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Echo stub standing in for the sqrt unit: output follows input after L cycles.
  always_ff @(posedge clk) begin
    pipe[0] <= sqrt_in_data;
    for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
  end
  assign sqrt_out_data = pipe[L-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    nxt();
    nxt();
    reset = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && busy; i++) nxt();
    smp();
    check("drain_busy", 32'(busy), 32'd0);
    nxt();
  endtask

  initial begin
    smp();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_sqrt_in", 32'(sqrt_in_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    nxt();
    req_valid = '0;
    reset = 1'b1;
    nxt();
    // single request, echo latency
    req_valid = 4'b0001;
    req_data  = {16'd0, 16'd0, 16'd0, 16'd100};
    smp();
    check("single_ready", 32'(req_ready), 32'h1);
    nxt();
    req_valid = '0;
    smp();
    check("single_sqrt_in", 32'(sqrt_in_data), 32'd100);
    check("single_busy", 32'(busy), 32'd1);
    repeat (18) nxt();
    smp();
    check("single_early", 32'(rsp_valid), 32'd0);
    nxt();
    smp();
    check("single_rsp_valid", 32'(rsp_valid), 32'h1);
    check("single_rsp_data", 32'(rsp_data), 32'd100);
    nxt();
    smp();
    check("single_after_valid", 32'(rsp_valid), 32'd0);
    check("single_after_busy", 32'(busy), 32'd0);
    check("single_hold_data", 32'(rsp_data), 32'd100);
    nxt();
    // all four requesters back to back
    do_reset();
    req_valid = 4'b1111;
    req_data  = {16'd4, 16'd3, 16'd2, 16'd1};
    for (int k = 0; k < 5; k++) begin
      smp();
      check($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(1) << (k % 4));
      nxt();
    end
    req_valid = '0;
    repeat (15) nxt();
    for (int k = 0; k < 5; k++) begin
      smp();
      check($sformatf("rr_rsp_valid%0d", k), 32'(rsp_valid), 32'(1) << (k % 4));
      check($sformatf("rr_rsp_data%0d", k), 32'(rsp_data), 32'((k % 4) + 1));
      nxt();
    end
    smp();
    check("rr_done_busy", 32'(busy), 32'd0);
    nxt();
    // fairness: 2 held, 0 always requesting
    do_reset();
    req_valid = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      smp();
      check($sformatf("fair%0d", k), 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h4);
      nxt();
    end
    req_valid = '0;
    drain();
    // enable gating
    do_reset();
    enable = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      smp();
      check($sformatf("en_off%0d", k), 32'(req_ready), 32'd0);
      nxt();
    end
    enable = 1'b1;
    smp();
    check("en_on", 32'(req_ready), 32'h1);
    nxt();
    req_valid = '0;
    drain();
    // reset mid-flight discards everything
    do_reset();
    req_valid = 4'b0111;
    req_data  = {16'd0, 16'd7, 16'd8, 16'd9};
    repeat (3) nxt();
    req_valid = '0;
    repeat (2) nxt();
    reset = 1'b0;
    smp();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rsp", 32'(rsp_valid), 32'd0);
    nxt();
    nxt();
    reset = 1'b1;
    seen = '0;
    for (int k = 0; k < 33; k++) begin
      smp();
      seen |= rsp_valid;
      nxt();
    end
    check("midrst_no_rsp", 32'(seen), 32'd0);
    check("midrst_busy_end", 32'(busy), 32'd0);
    req_valid = 4'b1111;
    smp();
    check("midrst_next_grant", 32'(req_ready), 32'h1);
    nxt();
    req_valid = '0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
